// File: rtl/product_bcd_converter_if.sv
// product_bcd_converter_if: Start/Busy/Valid handshake and result bus of the BCD converter.
// The optional Seg/SegNeg display signals exist only when PRODUCT_BCD_SEG_EN is defined.
interface product_bcd_converter_if #(parameter int WIDTH = 16, parameter int DIGITS = 5);
  logic Start;
  logic Signed;
  logic [WIDTH-1:0] Product;
  logic Busy;
  logic Valid;
  logic Neg;
  logic [4*DIGITS-1:0] Bcd;
`ifdef PRODUCT_BCD_SEG_EN
  logic [7*DIGITS-1:0] Seg;
  logic SegNeg;
  modport master (output Start, Signed, Product, input Busy, Valid, Neg, Bcd, Seg, SegNeg);
  modport slave (input Start, Signed, Product, output Busy, Valid, Neg, Bcd, Seg, SegNeg);
`else
  modport master (output Start, Signed, Product, input Busy, Valid, Neg, Bcd);
  modport slave (input Start, Signed, Product, output Busy, Valid, Neg, Bcd);
`endif
endinterface

// File: rtl/product_bcd_converter.sv
// product_bcd_converter: sequential double-dabble of the multiplier product into sign + BCD digits.
// Define PRODUCT_BCD_SEG_EN to add active-low seven-segment outputs decoded from the registered result.
module product_bcd_converter #(
  parameter int WIDTH = 16,
  parameter int DIGITS = 5
) (
  input logic Clk,
  input logic Reset,
  product_bcd_converter_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] mag;
  logic [4*DIGITS-1:0] scratch, adj;
  logic [4*DIGITS+WIDTH-1:0] sh;
  logic [CW-1:0] cnt;
  logic neg_r;
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
    sh = {adj, mag} << 1;
  end
  // Sign travels with the conversion and is published together with Bcd at DONE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      mag <= '0;
      scratch <= '0;
      cnt <= '0;
      neg_r <= 1'b0;
      bus.Busy <= 1'b0;
      bus.Valid <= 1'b0;
      bus.Neg <= 1'b0;
      bus.Bcd <= '0;
    end else begin
      case (state)
        IDLE: if (bus.Start) begin
          mag <= bus.Signed && bus.Product[WIDTH-1] ? -bus.Product : bus.Product;
          neg_r <= bus.Signed && bus.Product[WIDTH-1];
          scratch <= '0;
          cnt <= '0;
          bus.Valid <= 1'b0;
          bus.Busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          scratch <= sh[4*DIGITS+WIDTH-1:WIDTH];
          mag <= sh[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          bus.Bcd <= scratch;
          bus.Neg <= neg_r;
          bus.Valid <= 1'b1;
          bus.Busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PRODUCT_BCD_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction
  always_comb begin
    bus.Seg = '1;
    for (int i = 0; i < DIGITS; i++)
      bus.Seg[7*i+:7] = bus.Valid ? seg7(bus.Bcd[4*i+:4]) : 7'h7F;
    bus.SegNeg = ~bus.Neg;
  end
`endif
endmodule
